// File: rtl/plic_lite_pkg.sv
// -----------------------------------------------------------------------------
// plic_lite_pkg
// Shared definitions for the plic_lite interrupt arbiter:
//   - register byte offsets and their word indices (address bits [7:2])
//   - INT_BUS: width of the interrupt ID bus, matching the core's int_flag_i
//   - PLIC_ID_NONE: ID value meaning "no interrupt"
//   - reg_sel_e / decode_word(): register decode shared by read and write paths
// -----------------------------------------------------------------------------
package plic_lite_pkg;

   localparam int INT_BUS = 8;
   typedef logic [INT_BUS-1:0] int_id_t;

   localparam int_id_t PLIC_ID_NONE = 8'h0;

   localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;
   localparam logic [7:0] PLIC_PENDING   = 8'h40;
   localparam logic [7:0] PLIC_ENABLE    = 8'h44;
   localparam logic [7:0] PLIC_THRESHOLD = 8'h48;
   localparam logic [7:0] PLIC_CLAIM     = 8'h4C;

   localparam logic [5:0] PLIC_PRIO_BASE_W = PLIC_PRIO_BASE[7:2];
   localparam logic [5:0] PLIC_PENDING_W   = PLIC_PENDING[7:2];
   localparam logic [5:0] PLIC_ENABLE_W    = PLIC_ENABLE[7:2];
   localparam logic [5:0] PLIC_THRESHOLD_W = PLIC_THRESHOLD[7:2];
   localparam logic [5:0] PLIC_CLAIM_W     = PLIC_CLAIM[7:2];

   typedef enum logic [2:0] {
      REG_NONE,
      REG_PRIO,
      REG_PENDING,
      REG_ENABLE,
      REG_THRESHOLD,
      REG_CLAIM
   } reg_sel_e;

   // Priority words exist only for implemented sources and never overlap
   // the control block starting at PLIC_PENDING.
   function automatic reg_sel_e decode_word(input logic [5:0] word, input int num_src);
      reg_sel_e sel;
      sel = REG_NONE;
      if (word >= PLIC_PRIO_BASE_W && word < PLIC_PENDING_W &&
          int'(word - PLIC_PRIO_BASE_W) < num_src) begin
         sel = REG_PRIO;
      end else begin
         case (word)
            PLIC_PENDING_W:   sel = REG_PENDING;
            PLIC_ENABLE_W:    sel = REG_ENABLE;
            PLIC_THRESHOLD_W: sel = REG_THRESHOLD;
            PLIC_CLAIM_W:     sel = REG_CLAIM;
            default:          sel = REG_NONE;
         endcase
      end
      return sel;
   endfunction

endpackage

// File: rtl/plic_lite_if.sv
// -----------------------------------------------------------------------------
// plic_lite_if
// Word-addressed peripheral register port of plic_lite.
//   we_i   : write strobe          re_i   : read strobe
//   addr_i : byte address [7:0]    data_i : write data [31:0]
//   data_o : read data [31:0], valid the cycle after re_i
// Modports: master (bus side), slave (plic_lite side).
// -----------------------------------------------------------------------------
interface plic_lite_if;
   logic        we_i;
   logic        re_i;
   logic [7:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;

   modport master (output we_i, re_i, addr_i, data_i, input data_o);
   modport slave  (input we_i, re_i, addr_i, data_i, output data_o);
endinterface

// File: rtl/plic_lite_gateway.sv
// -----------------------------------------------------------------------------
// plic_lite_gateway
// Per-source gateway: turns a level interrupt into a single pending request
// and holds the source off while software services it.
//   clk, rst    : clock, synchronous active-high reset
//   irq         : level interrupt line
//   claim       : this source was claimed this cycle
//   complete    : software completed this source this cycle
//   pending     : request waiting to be claimed
//   in_service  : claimed and not yet completed
// Build option PLIC_LITE_SYNC_EN: irq passes through a 2-flop synchronizer.
// -----------------------------------------------------------------------------
module plic_lite_gateway (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic claim,
   input  logic complete,
   output logic pending,
   output logic in_service
);

   logic irq_g;

`ifdef PLIC_LITE_SYNC_EN
   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= irq;
         sync_q2 <= sync_q1;
      end
   end

   assign irq_g = sync_q2;
`else
   assign irq_g = irq;
`endif

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would chain updates within one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= 1'b0;
         in_service <= 1'b0;
      end else begin
         // A still-high level re-pends only once in_service is already clear,
         // i.e. one cycle after the completing write.
         if (claim) begin
            pending <= 1'b0;
         end else if (irq_g && !pending && !in_service) begin
            pending <= 1'b1;
         end
         // Complete wins over a same-cycle claim of the same ID.
         if (complete) begin
            in_service <= 1'b0;
         end else if (claim) begin
            in_service <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/plic_lite.sv
// -----------------------------------------------------------------------------
// plic_lite
// Platform-level interrupt arbiter feeding the core's external interrupt input.
//   clk, rst    : clock, synchronous active-high reset
//   irq_i       : NUM_SRC level interrupt lines, bit k is source ID k+1
//   bus         : plic_lite_if.slave register port (priority, pending, enable,
//                 threshold, claim/complete)
//   int_flag_o  : registered winning source ID, 0 when nothing is eligible
// Build option PLIC_LITE_SYNC_EN: synchronize irq_i inside each gateway
// (irq-to-flag latency 4 cycles instead of 2).
// -----------------------------------------------------------------------------
module plic_lite
   import plic_lite_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int PRIO_W  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_i,
   plic_lite_if.slave         bus,
   output int_id_t            int_flag_o
);

   logic [PRIO_W-1:0]  prio_q [NUM_SRC];
   logic [NUM_SRC-1:0] enable_q;
   logic [PRIO_W-1:0]  threshold_q;

   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] in_service;
   logic [NUM_SRC-1:0] claim_vec;
   logic [NUM_SRC-1:0] complete_vec;

   logic [5:0]         word;
   reg_sel_e           sel;
   logic               claim_rd;
   logic               complete_wr;
   int_id_t            complete_id;
   int_id_t            best_id;
   logic [PRIO_W-1:0]  best_prio;
   logic [31:0]        rdata;
   logic               unused_bits;

   assign word        = bus.addr_i[7:2];
   assign sel         = decode_word(word, NUM_SRC);
   assign claim_rd    = bus.re_i && (sel == REG_CLAIM);
   assign complete_wr = bus.we_i && (sel == REG_CLAIM);
   assign complete_id = bus.data_i[7:0];
   assign unused_bits = ^{bus.data_i, bus.addr_i[1:0]};

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      best_id   = PLIC_ID_NONE;
      best_prio = '0;
      // Strict '>' keeps the lowest ID on equal priority; best_prio starting
      // at 0 is safe because an eligible source always has priority >= 1.
      for (int i = 0; i < NUM_SRC; i++) begin
         if (pending[i] && enable_q[i] && (prio_q[i] > threshold_q) &&
             (prio_q[i] > best_prio)) begin
            best_prio = prio_q[i];
            best_id   = int_id_t'(i + 1);
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      assign claim_vec[g]    = claim_rd && (best_id == int_id_t'(g + 1));
      assign complete_vec[g] = complete_wr && (complete_id == int_id_t'(g + 1));

      plic_lite_gateway u_gateway (
         .clk        (clk),
         .rst        (rst),
         .irq        (irq_i[g]),
         .claim      (claim_vec[g]),
         .complete   (complete_vec[g]),
         .pending    (pending[g]),
         .in_service (in_service[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the priority array is a small set of flops, not a RAM, so it
         // is cleared element by element like any other register.
         for (int i = 0; i < NUM_SRC; i++) begin
            prio_q[i] <= '0;
         end
         enable_q    <= '0;
         threshold_q <= '0;
      end else if (bus.we_i) begin
         case (sel)
            REG_PRIO: begin
               for (int i = 0; i < NUM_SRC; i++) begin
                  if (word == (PLIC_PRIO_BASE_W + 6'(i))) begin
                     prio_q[i] <= bus.data_i[PRIO_W-1:0];
                  end
               end
            end
            REG_ENABLE:    enable_q    <= bus.data_i[NUM_SRC-1:0];
            REG_THRESHOLD: threshold_q <= bus.data_i[PRIO_W-1:0];
            default: ;
         endcase
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         REG_PRIO: begin
            for (int i = 0; i < NUM_SRC; i++) begin
               if (word == (PLIC_PRIO_BASE_W + 6'(i))) begin
                  rdata[PRIO_W-1:0] = prio_q[i];
               end
            end
         end
         REG_PENDING:   rdata[NUM_SRC-1:0] = pending;
         REG_ENABLE:    rdata[NUM_SRC-1:0] = enable_q;
         REG_THRESHOLD: rdata[PRIO_W-1:0]  = threshold_q;
         REG_CLAIM:     rdata[INT_BUS-1:0] = best_id;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.data_o <= '0;
         int_flag_o <= PLIC_ID_NONE;
      end else begin
         int_flag_o <= best_id;
         if (bus.re_i) begin
            bus.data_o <= rdata;
         end
      end
   end

endmodule

// File: tb/tb_plic_lite.sv
// -----------------------------------------------------------------------------
// tb_plic_lite
// Self-checking bench for plic_lite: directed scenarios with literal
// expectations, then randomized register/irq traffic. A behavioural model of
// the interrupt controller predicts int_flag_o and data_o every cycle.
// -----------------------------------------------------------------------------
module tb_plic_lite;
   import plic_lite_pkg::*;

   localparam int NUM_SRC = 8;
   localparam int PRIO_W  = 3;
`ifdef PLIC_LITE_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_SRC-1:0] irq;
   int_id_t            int_flag;

   int n_checks = 0;
   int n_pass   = 0;

   plic_lite_if bus ();

   plic_lite #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .irq_i      (irq),
      .bus        (bus.slave),
      .int_flag_o (int_flag)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act === exp) n_pass = n_pass + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model (indexed by source ID) ----------------
   int                 m_prio [32];
   bit                 m_en   [32];
   bit                 m_pend [32];
   bit                 m_insv [32];
   int                 m_thr;
   int                 m_flag;
   logic [31:0]        m_rdata;
   logic [NUM_SRC-1:0] m_s1, m_s2;

   initial begin
      for (int id = 0; id < 32; id++) begin
         m_prio[id] = 0; m_en[id] = 0; m_pend[id] = 0; m_insv[id] = 0;
      end
      m_thr = 0; m_flag = 0; m_rdata = '0; m_s1 = '0; m_s2 = '0;
   end

   // Highest priority among pending, enabled, above-threshold sources;
   // lowest ID among equals.
   function automatic int model_best();
      int best = 0;
      int bp   = 0;
      for (int id = 1; id <= NUM_SRC; id++) begin
         if (m_pend[id] && m_en[id] && m_prio[id] > m_thr && m_prio[id] > bp) begin
            bp   = m_prio[id];
            best = id;
         end
      end
      return best;
   endfunction

   function automatic logic [31:0] model_read(input logic [7:0] a, input int best);
      int w = int'(a) / 4;
      logic [31:0] v = '0;
      if (w < NUM_SRC) v = 32'(m_prio[w + 1]);
      else if (w == 16) begin
         for (int id = 1; id <= NUM_SRC; id++) if (m_pend[id]) v = v | (32'd1 << (id - 1));
      end else if (w == 17) begin
         for (int id = 1; id <= NUM_SRC; id++) if (m_en[id]) v = v | (32'd1 << (id - 1));
      end else if (w == 18) v = 32'(m_thr);
      else if (w == 19) v = 32'(best);
      return v;
   endfunction

   always @(posedge clk) begin
      automatic int   best      = model_best();
      automatic int   claimed   = 0;
      automatic int   completed = 0;
      automatic int   w         = int'(bus.addr_i) / 4;
      automatic int   cid       = int'(bus.data_i[7:0]);
      automatic logic seen;
      if (rst) begin
         for (int id = 0; id < 32; id++) begin
            m_prio[id] <= 0; m_en[id] <= 0; m_pend[id] <= 0; m_insv[id] <= 0;
         end
         m_thr <= 0; m_flag <= 0; m_rdata <= '0; m_s1 <= '0; m_s2 <= '0;
      end else begin
         m_flag <= best;
         if (bus.re_i) m_rdata <= model_read(bus.addr_i, best);
         if (bus.re_i && w == 19) claimed = best;
         if (bus.we_i && w == 19 && cid >= 1 && cid <= NUM_SRC) completed = cid;
         for (int id = 1; id <= NUM_SRC; id++) begin
`ifdef PLIC_LITE_SYNC_EN
            seen = m_s2[id-1];
`else
            seen = irq[id-1];
`endif
            if (id == claimed) m_pend[id] <= 1'b0;
            else if (seen && !m_pend[id] && !m_insv[id]) m_pend[id] <= 1'b1;
            if (id == completed) m_insv[id] <= 1'b0;
            else if (id == claimed) m_insv[id] <= 1'b1;
         end
         if (bus.we_i) begin
            if (w < NUM_SRC) m_prio[w + 1] <= int'(bus.data_i[PRIO_W-1:0]);
            else if (w == 17) for (int id = 1; id <= NUM_SRC; id++) m_en[id] <= bus.data_i[id-1];
            else if (w == 18) m_thr <= int'(bus.data_i[PRIO_W-1:0]);
         end
         m_s1 <= irq;
         m_s2 <= m_s1;
      end
   end

   // Outputs are registered; compare them on the falling edge every cycle.
   always @(negedge clk) begin
      check("model_flag", 32'(int_flag), 32'(m_flag));
      check("model_data_o", bus.data_o, m_rdata);
   end

   // ---------------- stimulus helpers (called just after a falling edge) -----
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      bus.we_i = 1'b1; bus.addr_i = a; bus.data_i = d;
      @(negedge clk);
      bus.we_i = 1'b0;
   endtask

   task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
      bus.re_i = 1'b1; bus.addr_i = a;
      @(negedge clk);
      bus.re_i = 1'b0;
      check(name, bus.data_o, exp);
   endtask

   initial begin
      rst = 1'b1; irq = '0;
      bus.we_i = 1'b0; bus.re_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      check("rst_flag", 32'(int_flag), 32'd0);
      check("rst_data_o", bus.data_o, 32'd0);
      rd_check("rst_pending", 8'h40, 32'd0);
      rd_check("rst_enable", 8'h44, 32'd0);
      rd_check("rst_threshold", 8'h48, 32'd0);
      rd_check("rst_claim", 8'h4C, 32'd0);
      wr(8'h40, 32'hFFFF_FFFF);
      rd_check("pending_ro", 8'h40, 32'd0);
      rd_check("unmapped_rd", 8'h50, 32'd0);

      // Single source, latency and claim
      wr(8'h08, 32'd2); wr(8'h44, 32'h04); wr(8'h48, 32'd1);
      rd_check("prio3_rd", 8'h08, 32'd2);
      irq = 8'h04;
      repeat (LAT - 1) tick();
      check("lat_early", 32'(int_flag), 32'd0);
      tick();
      check("lat_flag3", 32'(int_flag), 32'd3);
      rd_check("claim3", 8'h4C, 32'd3);
      tick();
      check("flag_after_claim", 32'(int_flag), 32'd0);
      rd_check("pend_after_claim", 8'h40, 32'd0);
      irq = '0;
      wr(8'h4C, 32'd3);

      // Priority order and tie-break
      wr(8'h04, 32'd4); wr(8'h10, 32'd4); wr(8'h18, 32'd6);
      wr(8'h44, 32'h52); wr(8'h48, 32'd0);
      irq = 8'h52; tick(); irq = '0;
      repeat (LAT + 1) tick();
      check("flag7", 32'(int_flag), 32'd7);
      rd_check("claim7", 8'h4C, 32'd7); wr(8'h4C, 32'd7);
      rd_check("claim2", 8'h4C, 32'd2); wr(8'h4C, 32'd2);
      rd_check("claim5", 8'h4C, 32'd5); wr(8'h4C, 32'd5);
      rd_check("claim_empty", 8'h4C, 32'd0);

      // Held level: no re-pend while in service, re-pend after complete
      wr(8'h00, 32'd1); wr(8'h44, 32'h01);
      irq = 8'h01;
      repeat (LAT + 1) tick();
      check("flag1", 32'(int_flag), 32'd1);
      rd_check("claim1", 8'h4C, 32'd1);
      repeat (3) tick();
      rd_check("no_repend", 8'h40, 32'd0);
      wr(8'h4C, 32'd1);
      rd_check("repend_next", 8'h40, 32'd0);
      rd_check("repend_set", 8'h40, 32'h01);
      check("flag1_again", 32'(int_flag), 32'd1);
      irq = '0;
      rd_check("claim1b", 8'h4C, 32'd1); wr(8'h4C, 32'd1);

      // Threshold gating
      wr(8'h0C, 32'd3); wr(8'h44, 32'h08); wr(8'h48, 32'd3);
      irq = 8'h08; tick(); irq = '0;
      repeat (LAT + 1) tick();
      check("thr_block_flag", 32'(int_flag), 32'd0);
      rd_check("thr_block_claim", 8'h4C, 32'd0);
      rd_check("thr_pend_kept", 8'h40, 32'h08);
      wr(8'h48, 32'd2);
      check("thr_flag_same_cycle", 32'(int_flag), 32'd0);
      tick();
      check("thr_flag4", 32'(int_flag), 32'd4);
      rd_check("claim4", 8'h4C, 32'd4); wr(8'h4C, 32'd4);

      // Spurious complete, then reset during a claim
      wr(8'h14, 32'd5); wr(8'h44, 32'h20);
      irq = 8'h20; tick(); irq = '0;
      repeat (LAT + 1) tick();
      wr(8'h4C, 32'd6);
      rd_check("spurious_pend", 8'h40, 32'h20);
      check("spurious_flag", 32'(int_flag), 32'd6);
      rst = 1'b1; bus.re_i = 1'b1; bus.addr_i = 8'h4C;
      tick();
      rst = 1'b0; bus.re_i = 1'b0;
      check("rst_mid_data_o", bus.data_o, 32'd0);
      check("rst_mid_flag", 32'(int_flag), 32'd0);
      rd_check("rst_mid_pending", 8'h40, 32'd0);
      rd_check("rst_mid_enable", 8'h44, 32'd0);
      rd_check("rst_mid_thr", 8'h48, 32'd0);
      rd_check("rst_mid_prio6", 8'h14, 32'd0);
      rd_check("rst_mid_claim", 8'h4C, 32'd0);

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         automatic int k = int'($urandom_range(0, 9));
         automatic logic [31:0] rnd = $urandom;
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 5) == 0) irq = irq ^ NUM_SRC'(1 << $urandom_range(0, NUM_SRC - 1));
         bus.we_i = ($urandom_range(0, 3) == 0);
         bus.re_i = ($urandom_range(0, 2) == 0);
         if (k < 4)       bus.addr_i = 8'h4C;
         else if (k == 4) bus.addr_i = 8'h40;
         else if (k == 5) bus.addr_i = 8'h44;
         else if (k == 6) bus.addr_i = 8'h48;
         else             bus.addr_i = 8'($urandom_range(0, 255));
         if (bus.addr_i[7:2] == 6'h13) bus.data_i = {rnd[31:8], 8'($urandom_range(0, NUM_SRC + 1))};
         else                          bus.data_i = rnd;
         tick();
      end
      rst = 1'b0; bus.we_i = 1'b0; bus.re_i = 1'b0; irq = '0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
